// File: rtl/banco_registradores.sv
// 32 x 32-bit register file: two combinational read ports with write-first
// bypass, one synchronous write port, register 0 hardwired to zero, $sp preset.
module banco_registradores (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        reg_write,
   input  logic [4:0]  read_reg1,
   input  logic [4:0]  read_reg2,
   input  logic [4:0]  write_reg,
   input  logic [31:0] write_data,
   output logic [31:0] read_data1,
   output logic [31:0] read_data2,
   output logic        write_busy,
   output logic [4:0]  last_written
);

   localparam logic [4:0]  SP_IDX   = 5'd29;
   localparam logic [31:0] SP_RESET = 32'd227;

   logic [31:0] regs [32];
   logic        wr_en;

   assign wr_en = reg_write && (write_reg != 5'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (5'(i) == SP_IDX) ? SP_RESET : 32'd0;
         end
         write_busy   <= 1'b0;
         last_written <= 5'd0;
      end else begin
         if (wr_en) begin
            regs[write_reg] <= write_data;
            last_written    <= write_reg;
         end
         write_busy <= wr_en;
      end
   end

   // Bypass is gated by reset_n so reads show reset values while in reset.
   always_comb begin
      read_data1 = regs[read_reg1];
      if (read_reg1 == 5'd0)
         read_data1 = 32'd0;
      else if (reset_n && wr_en && (read_reg1 == write_reg))
         read_data1 = write_data;
   end

   always_comb begin
      read_data2 = regs[read_reg2];
      if (read_reg2 == 5'd0)
         read_data2 = 32'd0;
      else if (reset_n && wr_en && (read_reg2 == write_reg))
         read_data2 = write_data;
   end

endmodule

// File: doc/banco_registradores.md
BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 SHALL have no parameters; widths are fixed (32 registers x 32 bits).
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL provide these ports:

| Port | Dir | Width | Meaning |
|---|---|---|---|
| clk | input | 1 | Rising-edge clock. |
| reset_n | input | 1 | Asynchronous, active-low reset. |
| reg_write | input | 1 | Write enable. |
| read_reg1 | input | 5 | Read address, port A. |
| read_reg2 | input | 5 | Read address, port B. |
| write_reg | input | 5 | Write address. |
| write_data | input | 32 | Write data, driven by the DataSrc selector output. |
| read_data1 | output | 32 | Port A data. |
| read_data2 | output | 32 | Port B data. |
| write_busy | output | 1 | High for exactly one cycle after an accepted write. |
| last_written | output | 5 | Index of the most recent committed write. |

Function
REQ-004 SHALL hold 32 registers of 32 bits, indexed 0..31.
REQ-005 Register 0 SHALL always read 32'h00000000; writes to index 0 SHALL be discarded.
REQ-006 Writes SHALL commit on the rising clk edge when reg_write=1 and write_reg!=0, storing write_data into register[write_reg].
REQ-007 Reads SHALL be combinational: read_dataN = register[read_regN], with no clock latency.
REQ-008 Write-first bypass, same-cycle case:
- Condition: reg_write=1, write_reg!=0 and read_regN==write_reg.
- read_dataN SHALL output write_data combinationally in that cycle, before the commit edge.
REQ-009 Both read ports SHALL operate independently; read_reg1==read_reg2 SHALL return identical data on both ports, bypass included.
REQ-010 write_busy behaviour:
- SHALL go to 1 on the edge following an accepted write (REQ-006 conditions).
- SHALL return to 0 on the next edge unless another accepted write occurs.
- Back-to-back writes SHALL hold it at 1 continuously.
REQ-011 last_written SHALL update to write_reg on every accepted write.
- It SHALL hold its value otherwise.
- Writes to index 0 SHALL NOT update it.
REQ-012 reg_write=0 SHALL leave all registers, write_busy (which then clears next edge) and last_written unchanged.
REQ-013 write_data and write_reg SHALL be sampled only at the clk edge; glitches between edges SHALL NOT alter stored state, only bypassed read outputs.
REQ-014 Out-of-range behaviour SHALL NOT exist: all 5-bit indices are valid, and no X SHALL propagate from an unwritten register after reset.

Reset
REQ-015 On reset_n=0, asynchronously and regardless of clk:
- Registers 1..28 and 30..31 SHALL clear to 0.
- Register 29 ($sp) SHALL load 32'd227.
- write_busy SHALL be 0.
- last_written SHALL be 5'd0.
REQ-016 Reset asserted during a write edge SHALL win: the write SHALL be lost and the reset values SHALL stand.
REQ-017 While reset_n=0, read outputs SHALL reflect the reset values (REQ-015); bypass SHALL be disabled.
REQ-018 The first write SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-019 Reset check: pulse reset_n low mid-cycle -> read_reg1=29 gives 227; read_reg2=5 gives 0; write_busy=0; last_written=0.
REQ-020 Basic write/read: write 32'hDEADBEEF to reg 8 -> next cycle read_reg1=8 gives DEADBEEF; write_busy=1 for one cycle; last_written=8.
REQ-021 Register 0 protection: write 32'hFFFFFFFF to reg 0 -> read gives 0; write_busy stays 0; last_written unchanged.
REQ-022 Same-cycle bypass: reg_write=1, write_reg=12, write_data=32'h12345678 and read_reg1=read_reg2=12 in the same cycle -> both outputs show 12345678 before the edge.
REQ-023 Back-to-back writes: reg 3=1, reg 4=2, reg 3=3 on consecutive edges -> write_busy high for all three cycles; reg 3 reads 3; reg 4 reads 2; last_written=3.
REQ-024 Reset during write: drop reset_n coincident with a write of 32'hAAAA to reg 29 -> reg 29 reads 227 and last_written=0.
